// File: rtl/serial_add_sequencer_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding, width limit
// and the helper that sizes the bit counter.
package serial_add_sequencer_pkg;

   localparam int ADD_WIDTH_MAX = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // One extra bit beyond $clog2 so the counter never wraps before the final compare.
   function automatic int cntWidth(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/serial_add_sequencer_fa_cell.sv
// Single-bit full adder shared by every bit position of the serial adder.
// Purely combinational.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial WIDTH-bit adder: operands enter on a valid/ready handshake, are
// summed LSB first through one full-adder cell, and leave with cout/overflow.
module serial_add_sequencer
   import serial_add_sequencer_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow,
   output logic             busy
);

   localparam int             CNT_W    = cntWidth(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   if (WIDTH < 1 || WIDTH > ADD_WIDTH_MAX) begin : g_badWidth
      $error("serial_add_sequencer: WIDTH out of range");
   end

   state_t           r_state;
   state_t           w_nextState;
   logic [WIDTH-1:0] r_aSh;
   logic [WIDTH-1:0] r_bSh;
   logic [WIDTH-1:0] r_sum;
   logic [CNT_W-1:0] r_cnt;
   logic             r_carry;
   logic             r_cout;
   logic             r_overflow;

   logic             w_s;
   logic             w_co;
   logic             w_accept;
   logic             w_lastBit;
   logic             w_take;
   logic [WIDTH-1:0] w_sumShift;

   fa_cell u_faCell (
      .a  (r_aSh[0]),
      .b  (r_bSh[0]),
      .ci (r_carry),
      .s  (w_s),
      .co (w_co)
   );

   assign w_accept   = in_valid & in_ready;
   assign w_lastBit  = (r_state == ST_RUN) && (r_cnt == LAST_CNT);
   assign w_take     = (r_state == ST_DONE) & out_ready;
   assign w_sumShift = (r_sum >> 1) | (WIDTH'(w_s) << (WIDTH - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE: if (w_accept)  w_nextState = ST_RUN;
         ST_RUN:  if (w_lastBit) w_nextState = ST_DONE;
         ST_DONE: if (w_take)    w_nextState = ST_IDLE;
         default:                w_nextState = ST_IDLE;
      endcase
   end

   // in_ready looks at reset directly so nothing can be accepted on a reset edge.
   always_comb begin
      in_ready  = (r_state == ST_IDLE) & ~reset;
      out_valid = (r_state == ST_DONE);
      busy      = (r_state != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_aSh      <= '0;
         r_bSh      <= '0;
         r_sum      <= '0;
         r_cnt      <= '0;
         r_carry    <= 1'b0;
         r_cout     <= 1'b0;
         r_overflow <= 1'b0;
      end else if (w_accept) begin
         r_aSh   <= a;
         r_bSh   <= b;
         r_carry <= cin;
         r_cnt   <= '0;
         r_sum   <= '0;
      end else if (r_state == ST_RUN) begin
         r_sum   <= w_sumShift;
         r_aSh   <= r_aSh >> 1;
         r_bSh   <= r_bSh >> 1;
         r_carry <= w_co;
         r_cnt   <= r_cnt + CNT_W'(1);
         // r_carry here is still the carry into the MSB, which overflow needs.
         if (w_lastBit) begin
            r_cout     <= w_co;
            r_overflow <= r_carry ^ w_co;
         end
      end
   end

   assign sum      = r_sum;
   assign cout     = r_cout;
   assign overflow = r_overflow;

endmodule
